// File: rtl/vc_fifo_bank.sv
// vc_fifo_bank: NCH independent FIFOs sharing one write and one read port, with per-channel thresholds, flags and sticky errors.
// Define VC_FIFO_BANK_OCC_EN to add the packed per-channel occupancy output.
module vc_fifo_bank #(
    parameter int BW  = 6,
    parameter int LEN = 4,
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 wr,
    input  logic [CHW-1:0]       wr_ch,
    input  logic [BW-1:0]        data_in,
    input  logic                 rd,
    input  logic [CHW-1:0]       rd_ch,
    input  logic [NCH*LEN-1:0]   umbral_bajo,
    input  logic [NCH*LEN-1:0]   umbral_alto,
    output logic [BW-1:0]        data_out,
    output logic                 out_valid,
    output logic [CHW-1:0]       out_ch,
    output logic [NCH-1:0]       full,
    output logic [NCH-1:0]       empty,
    output logic [NCH-1:0]       almost_full,
    output logic [NCH-1:0]       almost_empty,
    output logic [NCH-1:0]       error,
`ifdef VC_FIFO_BANK_OCC_EN
    output logic [NCH*(LEN+1)-1:0] occupancy,
`endif
    output logic                 pause
);
    localparam int DEPTH = 2**LEN;
    logic [NCH-1:0] rok;
    logic [BW-1:0]  rdata [NCH];
    logic [BW-1:0]  rword;
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        localparam logic [CHW-1:0] ID = CHW'(i);
        logic [BW-1:0]  mem [DEPTH];
        logic [LEN-1:0] wptr, rptr;
        logic [LEN:0]   cnt;
        logic           wsel, rsel, wok, err;
        assign wsel            = wr && wr_ch == ID;
        assign rsel            = rd && rd_ch == ID;
        assign full[i]         = cnt == (LEN+1)'(DEPTH);
        assign empty[i]        = cnt == '0;
        assign rok[i]          = rsel && !empty[i];
        // a same-channel pop frees a slot this cycle, so a full channel still accepts the write
        assign wok             = wsel && (!full[i] || rok[i]);
        assign almost_full[i]  = cnt >= {1'b0, umbral_alto[i*LEN +: LEN]};
        assign almost_empty[i] = cnt <= {1'b0, umbral_bajo[i*LEN +: LEN]};
        assign rdata[i]        = mem[rptr];
        assign error[i]        = err;
`ifdef VC_FIFO_BANK_OCC_EN
        assign occupancy[i*(LEN+1) +: LEN+1] = cnt;
`endif
        always_ff @(posedge clk)
            if (reset_L && wok) mem[wptr] <= data_in;
        always_ff @(posedge clk)
            if (!reset_L) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
                err  <= 1'b0;
            end else begin
                if (wok) wptr <= wptr + LEN'(1);
                if (rok[i]) rptr <= rptr + LEN'(1);
                cnt <= cnt + (LEN+1)'(wok) - (LEN+1)'(rok[i]);
                err <= err | (wsel && !wok) | (rsel && empty[i]);
            end
    end
    assign pause = |almost_full;
    always_comb begin
        rword = '0;
        for (int k = 0; k < NCH; k++) rword = rok[k] ? rdata[k] : rword;
    end
    always_ff @(posedge clk)
        if (!reset_L) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
        end else begin
            out_valid <= |rok;
            if (|rok) begin
                data_out <= rword;
                out_ch   <= rd_ch;
            end
        end
endmodule
